en_tick_sequencer: RTL and testbench
====================================

// Module: en_tick_sequencer
// PURPOSE
//   Upstream enable source for the pulse counter stage: produces the 1-cycle
//   count-enable strobe (tick_en) that drives that counter's en input.
//   Divides clk by a programmable prescale.
//   Runs either continuously or for a fixed burst of ticks, under start/stop
//   control, and reports busy/done status to the controlling logic.
// PARAMETERS
//   PRESCALE_W  16  width of cfg_prescale; tick period = cfg_prescale+1 clk cycles
//   BURST_W      8  width of cfg_burst_len and tick_cnt
// PORTS
//   clk            input   1           clock, rising edge
//   rstn           input   1           reset, asynchronous, active-low
//   cfg_prescale   input   PRESCALE_W  tick period minus one; sampled on accepted start
//   cfg_burst_len  input   BURST_W     ticks per burst (mode 1); sampled on accepted start
//   cfg_mode       input   1           0 = continuous, 1 = burst; sampled on accepted start
//   start          input   1           1-cycle request to begin a run
//   stop           input   1           1-cycle request to abort a run
//   tick_en        output  1           1-cycle enable strobe to downstream counter
//   busy           output  1           1 while in RUN
//   done           output  1           1-cycle pulse when a burst completes normally
//   tick_cnt       output  BURST_W     ticks emitted in current/last run
// BEHAVIOUR
//   - Reset: state=IDLE, prescale counter=0, tick_en=0, busy=0, done=0, tick_cnt=0.
//     All outputs are registered.
//   - FSM states: IDLE, RUN, DONE.
//   - IDLE: start=1 && stop=0 -> RUN.
//     - Captures cfg_* into shadow registers.
//     - Clears prescale counter and tick_cnt.
//     - busy=1 from the next cycle.
//     - Exception: if cfg_mode=1 && cfg_burst_len=0, go to DONE instead. No ticks are emitted.
//   - RUN: prescale counter counts 0..P (P = captured prescale), then wraps to 0.
//     - tick_en=1 for exactly one cycle in the cycle after the counter equals P.
//     - First tick_en is P+1 cycles after the cycle start was sampled.
//     - Tick period is P+1. P=0 gives tick_en=1 every cycle.
//     - Each tick increments tick_cnt; it wraps modulo 2^BURST_W in continuous mode.
//   - Burst mode: the tick that makes tick_cnt equal the captured burst_len is
//     emitted, and the FSM then moves to DONE. No further ticks.
//   - DONE: done=1 for exactly one cycle, busy=0, then IDLE. start in DONE is ignored.
//   - stop: priority over everything.
//     - In RUN: next state IDLE, busy=0.
//     - A tick that would fire on the cycle after stop is suppressed.
//     - No done pulse; tick_cnt holds its value.
//     - In IDLE/DONE stop has no effect, except that it blocks a simultaneous start.
//   - start while in RUN: ignored. Config changes while in RUN: ignored (shadowed).
//   - Reset asserted mid-run: immediate return to reset values, no done pulse.
//   - tick_en is never asserted outside RUN.
// TESTING
//   1 Continuous, prescale=3: start at cycle 0 -> tick_en at cycles 4,8,12,...
//     tick_cnt=1,2,3; busy=1 from cycle 1.
//   2 Burst, prescale=1, burst_len=3: start -> 3 ticks at 2-cycle spacing.
//     done 1 cycle after the 3rd tick; busy drops with done; tick_cnt=3 held.
//   3 prescale=0 continuous for 300 cycles -> tick_en every cycle;
//     tick_cnt wraps 255->0; stop -> tick_en=0 next cycle, busy=0, no done.
//   4 Burst, burst_len=0 -> no tick_en, done pulse 1 cycle after start, busy stays 0.
//   5 start+stop same cycle in IDLE -> stays IDLE.
//     start during RUN and cfg change during RUN -> period/length unchanged.
//   6 rstn low mid-burst (after 2 of 5 ticks) -> all outputs 0 immediately,
//     no done; a new start runs a fresh 5-tick burst.

Source files
------------

// File: rtl/en_tick_sequencer.sv
// en_tick_sequencer: produces the 1-cycle count-enable strobe for the pulse
// counter stage. It divides clk by a programmable prescale and runs either
// continuously or for a fixed burst, with start/stop control and busy/done
// status. All outputs are registered.
module en_tick_sequencer #(
    parameter int PRESCALE_W = 16,
    parameter int BURST_W    = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic [BURST_W-1:0]    cfg_burst_len,
    input  logic                  cfg_mode,
    input  logic                  start,
    input  logic                  stop,
    output logic                  tick_en,
    output logic                  busy,
    output logic                  done,
    output logic [BURST_W-1:0]    tick_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRESC_ONE = PRESCALE_W'(1);
    localparam logic [BURST_W-1:0]    BURST_ONE = BURST_W'(1);

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic [PRESCALE_W-1:0]   presc_q, presc_d;
    logic [BURST_W-1:0]      burst_len_q, burst_len_d;
    logic                    mode_q, mode_d;
    logic                    tick_q, tick_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [BURST_W-1:0]      tick_cnt_q, tick_cnt_d;

    // State, shadow configuration and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            presc_cnt_q <= '0;
            presc_q     <= '0;
            burst_len_q <= '0;
            mode_q      <= 1'b0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            presc_cnt_q <= presc_cnt_d;
            presc_q     <= presc_d;
            burst_len_q <= burst_len_d;
            mode_q      <= mode_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    // Next-state logic. The accepting cycle counts as prescale step 0, so the
    // first tick lands P+1 cycles after start was sampled. The burst ends on the
    // cycle the final tick is visible, so busy stays high alongside that tick.
    always_comb begin
        state_d     = state_q;
        presc_cnt_d = presc_cnt_q;
        presc_d     = presc_q;
        burst_len_d = burst_len_q;
        mode_d      = mode_q;
        tick_d      = 1'b0;
        tick_cnt_d  = tick_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    presc_d     = cfg_prescale;
                    burst_len_d = cfg_burst_len;
                    mode_d      = cfg_mode;
                    tick_cnt_d  = '0;
                    presc_cnt_d = '0;
                    if (cfg_mode && (cfg_burst_len == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        if (cfg_prescale == '0) begin
                            tick_d     = 1'b1;
                            tick_cnt_d = BURST_ONE;
                        end else begin
                            presc_cnt_d = PRESC_ONE;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d     = ST_IDLE;
                    presc_cnt_d = '0;
                end else if (mode_q && tick_q && (tick_cnt_q == burst_len_q)) begin
                    state_d     = ST_DONE;
                    presc_cnt_d = '0;
                end else if (presc_cnt_q == presc_q) begin
                    tick_d      = 1'b1;
                    presc_cnt_d = '0;
                    tick_cnt_d  = tick_cnt_q + BURST_ONE;
                end else begin
                    presc_cnt_d = presc_cnt_q + PRESC_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign tick_en  = tick_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_en_tick_sequencer.sv
// Directed testbench for en_tick_sequencer. Inputs change 1 time unit after a
// rising edge and outputs are checked at that same point, so "cycle k" is the
// interval in which the inputs set at step k are sampled by the next edge.
module tb_en_tick_sequencer;

    logic        clk;
    logic        rstn;
    logic [15:0] cfg_prescale;
    logic [7:0]  cfg_burst_len;
    logic        cfg_mode;
    logic        start;
    logic        stop;
    logic        tick_en;
    logic        busy;
    logic        done;
    logic [7:0]  tick_cnt;

    int vectors;
    int miscompares;

    en_tick_sequencer #(.PRESCALE_W(16), .BURST_W(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .cfg_prescale (cfg_prescale),
        .cfg_burst_len(cfg_burst_len),
        .cfg_mode     (cfg_mode),
        .start        (start),
        .stop         (stop),
        .tick_en      (tick_en),
        .busy         (busy),
        .done         (done),
        .tick_cnt     (tick_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic sp, input logic md,
                                 input logic [15:0] pre, input logic [7:0] len);
        start         = st;
        stop          = sp;
        cfg_mode      = md;
        cfg_prescale  = pre;
        cfg_burst_len = len;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int k, input logic t, input logic b,
                            input logic d, input logic [7:0] c);
        checkOutput($sformatf("%s tick_en k=%0d", tag, k), {31'd0, tick_en}, {31'd0, t});
        checkOutput($sformatf("%s busy k=%0d", tag, k), {31'd0, busy}, {31'd0, b});
        checkOutput($sformatf("%s done k=%0d", tag, k), {31'd0, done}, {31'd0, d});
        checkOutput($sformatf("%s tick_cnt k=%0d", tag, k), {24'd0, tick_cnt}, {24'd0, c});
    endtask

    initial begin
        int ec;
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 8'd0);

        // Reset values
        stepCycle();
        stepCycle();
        checkAll("reset", 0, 1'b0, 1'b0, 1'b0, 8'd0);
        rstn = 1'b1;
        stepCycle();
        checkAll("post-reset", 0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Test 1: continuous, prescale 3 -> ticks at 4, 8, 12
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd3, 8'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd3, 8'd0);
        for (int k = 1; k <= 12; k++) begin
            checkAll("t1", k, (k % 4) == 0, 1'b1, 1'b0, 8'(k / 4));
            if (k < 12) stepCycle();
        end
        stop = 1'b1;
        stepCycle();
        stop = 1'b0;
        checkAll("t1 stop", 13, 1'b0, 1'b0, 1'b0, 8'd3);
        stepCycle();
        checkAll("t1 idle", 14, 1'b0, 1'b0, 1'b0, 8'd3);

        // Test 2: burst, prescale 1, length 3 -> ticks at 2,4,6, done at 7
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd1, 8'd3);
        stepCycle();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            ec = (k >= 2 ? 1 : 0) + (k >= 4 ? 1 : 0) + (k >= 6 ? 1 : 0);
            checkAll("t2", k, (k == 2) || (k == 4) || (k == 6), (k <= 6), (k == 7), 8'(ec));
            stepCycle();
        end

        // Test 3: prescale 0, continuous, 300 cycles, wrap, then stop
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd0, 8'd0);
        stepCycle();
        start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            checkOutput($sformatf("t3 tick_en k=%0d", k), {31'd0, tick_en}, 32'd1);
            checkOutput($sformatf("t3 tick_cnt k=%0d", k), {24'd0, tick_cnt}, 32'(k % 256));
            if (k < 300) stepCycle();
        end
        stop = 1'b1;
        stepCycle();
        stop = 1'b0;
        checkAll("t3 stop", 301, 1'b0, 1'b0, 1'b0, 8'd44);
        stepCycle();
        checkAll("t3 idle", 302, 1'b0, 1'b0, 1'b0, 8'd44);

        // Test 4: burst with length 0 -> immediate done, no ticks
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd5, 8'd0);
        stepCycle();
        start = 1'b0;
        checkAll("t4", 1, 1'b0, 1'b0, 1'b1, 8'd0);
        stepCycle();
        checkAll("t4", 2, 1'b0, 1'b0, 1'b0, 8'd0);
        stepCycle();
        checkAll("t4", 3, 1'b0, 1'b0, 1'b0, 8'd0);

        // Test 5a: start and stop together in IDLE -> stays idle
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, 8'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
        checkAll("t5a", 1, 1'b0, 1'b0, 1'b0, 8'd0);
        stepCycle();
        checkAll("t5a", 2, 1'b0, 1'b0, 1'b0, 8'd0);

        // Test 5b: burst P=2 len=4; config change and start during RUN,
        // start during DONE, none of which may take effect
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd2, 8'd4);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 8'd1);
        for (int k = 1; k <= 15; k++) begin
            ec = k / 3;
            if (ec > 4) ec = 4;
            checkAll("t5b", k, ((k % 3) == 0) && (k <= 12), (k <= 12), (k == 13), 8'(ec));
            start = (k == 3) || (k == 13);
            stepCycle();
        end
        start = 1'b0;

        // Test 6: reset mid-burst after 2 of 5 ticks, then a fresh burst
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd1, 8'd5);
        stepCycle();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            checkAll("t6 pre", k, (k == 2) || (k == 4), 1'b1, 1'b0, 8'(k / 2));
            stepCycle();
        end
        rstn = 1'b0;
        #1;
        checkAll("t6 in-reset", 5, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        rstn = 1'b1;
        stepCycle();
        checkAll("t6 after-reset", 6, 1'b0, 1'b0, 1'b0, 8'd0);
        stepCycle();
        checkAll("t6 after-reset", 7, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd1, 8'd5);
        stepCycle();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            ec = k / 2;
            if (ec > 5) ec = 5;
            checkAll("t6 fresh", k, ((k % 2) == 0) && (k <= 10), (k <= 10), (k == 11), 8'(ec));
            stepCycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
